serial_16b_rx: RTL and testbench

Receive-side counterpart of the DAC serial link: deserialises 16-bit words from an external SYNC/SCLK/DIN bus driven by the DAC serial transmitter. Used for transmitter loopback checking in hardware and as a receive path for serial peripherals using the same frame format. All three bus inputs are asynchronous to clk and are synchronised internally. SCLK is oversampled by clk; no logic is clocked by SCLK.

---
 rtl/serial_16b_rx.sv | 175 +++++++++++++++++
 tb/tb_serial_16b_rx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_16b_rx.sv
// serial_16b_rx: deserialises 16-bit MSB-first words from an asynchronous SYNC/SCLK/DIN bus, oversampled by clk.
// Optional per-frame counters are built when SERIAL_RX_FRAME_COUNT_EN is defined.
module serial_16b_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_BITS   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SYNC,
    input  logic        SCLK,
    input  logic        DIN,
`ifdef SERIAL_RX_FRAME_COUNT_EN
    input  logic        clr_counts,
    output logic [31:0] good_count,
    output logic [31:0] err_count,
`endif
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] sync_pipe_r;
    logic [SYNC_STAGES-1:0] sclk_pipe_r;
    logic [SYNC_STAGES-1:0] din_pipe_r;
    logic                   sync_s, sclk_s, din_s;
    logic                   sync_d_r, sclk_d_r, din_d_r;
    logic                   sync_fall_r, sync_rise_r, sclk_fall_r;
    state_t                 state_r, state_next_s;
    logic [WORD_BITS-1:0]   shreg_r, shift_word_s;
    logic [4:0]             cnt_r, shift_cnt_s;
    logic                   clear_s, shift_en_s, good_s, err_s;

    assign sync_s = sync_pipe_r[SYNC_STAGES-1];
    assign sclk_s = sclk_pipe_r[SYNC_STAGES-1];
    assign din_s  = din_pipe_r[SYNC_STAGES-1];

    // Input synchronisers; all three chains share one depth so the bus stays aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_pipe_r <= {SYNC_STAGES{1'b1}};
            sclk_pipe_r <= {SYNC_STAGES{1'b0}};
            din_pipe_r  <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_pipe_r <= {sync_pipe_r[SYNC_STAGES-2:0], SYNC};
            sclk_pipe_r <= {sclk_pipe_r[SYNC_STAGES-2:0], SCLK};
            din_pipe_r  <= {din_pipe_r[SYNC_STAGES-2:0], DIN};
        end
    end

    // Registered edge strobes; din_d_r is captured on the same edge so it lines up with sclk_fall_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d_r    <= 1'b1;
            sclk_d_r    <= 1'b0;
            din_d_r     <= 1'b0;
            sync_fall_r <= 1'b0;
            sync_rise_r <= 1'b0;
            sclk_fall_r <= 1'b0;
        end else begin
            sync_d_r    <= sync_s;
            sclk_d_r    <= sclk_s;
            din_d_r     <= din_s;
            sync_fall_r <= sync_d_r & ~sync_s;
            sync_rise_r <= ~sync_d_r & sync_s;
            sclk_fall_r <= sclk_d_r & ~sclk_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (sync_fall_r) state_next_s = SHIFT; else state_next_s = IDLE;
            SHIFT:   if (sync_rise_r) state_next_s = IDLE;  else state_next_s = SHIFT;
            default: state_next_s = IDLE;
        endcase
    end

    // Word and count after this cycle's bit, so a frame closing on the same cycle is judged on it.
    always_comb begin
        shift_word_s = shreg_r;
        shift_cnt_s  = cnt_r;
        if (sclk_fall_r) begin
            shift_word_s = {shreg_r[WORD_BITS-2:0], din_d_r};
            shift_cnt_s  = (cnt_r == 5'd17) ? 5'd17 : cnt_r + 5'd1;
        end else begin
            shift_word_s = shreg_r;
            shift_cnt_s  = cnt_r;
        end
    end

    // FSM output decode.
    always_comb begin
        clear_s    = 1'b0;
        shift_en_s = 1'b0;
        good_s     = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            IDLE: begin
                clear_s = sync_fall_r;
            end
            SHIFT: begin
                shift_en_s = sclk_fall_r;
                if (sync_rise_r) begin
                    if (shift_cnt_s == 5'(WORD_BITS)) begin
                        good_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    good_s = 1'b0;
                    err_s  = 1'b0;
                end
            end
            default: begin
                clear_s = 1'b0;
            end
        endcase
    end

    // Shift register, bit counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r    <= {WORD_BITS{1'b0}};
            cnt_r      <= 5'd0;
            data_out   <= 16'h0000;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (clear_s) begin
                shreg_r <= {WORD_BITS{1'b0}};
                cnt_r   <= 5'd0;
            end else if (shift_en_s) begin
                shreg_r <= shift_word_s;
                cnt_r   <= shift_cnt_s;
            end
            if (good_s) begin
                data_out <= shift_word_s[15:0];
            end
            data_valid <= good_s;
            frame_err  <= err_s;
            busy       <= (state_next_s == SHIFT);
        end
    end

`ifdef SERIAL_RX_FRAME_COUNT_EN
    // Frame statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_count <= 32'd0;
            err_count  <= 32'd0;
        end else if (clr_counts) begin
            good_count <= 32'd0;
            err_count  <= 32'd0;
        end else begin
            good_count <= good_count + {31'd0, data_valid};
            err_count  <= err_count + {31'd0, frame_err};
        end
    end
`endif

endmodule

// File: tb/tb_serial_16b_rx.sv
// Scoreboard bench for serial_16b_rx: a bus driver pushes expected frame outcomes, a monitor checks each pulse.
module tb_serial_16b_rx;

    typedef struct packed {
        logic        is_err;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SYNC = 1'b1;
    logic        SCLK = 1'b0;
    logic        DIN = 1'b0;
    logic [15:0] data_out;
    logic        data_valid, frame_err, busy;
`ifdef SERIAL_RX_FRAME_COUNT_EN
    logic        clr_counts = 1'b0;
    logic [31:0] good_count, err_count;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        q[$];
    logic [15:0] last_good = 16'h0000;

    serial_16b_rx #(.SYNC_STAGES(2), .WORD_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .SYNC(SYNC), .SCLK(SCLK), .DIN(DIN),
`ifdef SERIAL_RX_FRAME_COUNT_EN
        .clr_counts(clr_counts), .good_count(good_count), .err_count(err_count),
`endif
        .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame of nbits SCLK falls, half-period h clk cycles; pushes the expected outcome.
    task automatic send_frame(input logic [15:0] w, input int nbits, input int h,
                              input bit same_edge, input int gap);
        exp_t e;
        if (nbits == 16) begin
            e.is_err = 1'b0; e.data = w; last_good = w;
        end else begin
            e.is_err = 1'b1; e.data = last_good;
        end
        q.push_back(e);
        @(negedge clk);
        SYNC = 1'b0;
        repeat (h) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            DIN  = (i < 16) ? w[15-i] : 1'b0;
            SCLK = 1'b1;
            repeat (h) @(negedge clk);
            if (i == 8) chk("busy_mid_frame", {31'd0, busy}, 32'd1);
            SCLK = 1'b0;
            if (!(same_edge && i == nbits - 1)) repeat (h) @(negedge clk);
        end
        SYNC = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && (data_valid || frame_err)) begin
            exp_t e;
            n_vec++;
            if (data_valid && frame_err) begin
                n_err++;
                $display("FAIL pulse_exclusive: both data_valid and frame_err high");
            end else if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%h", data_valid, frame_err, data_out);
            end else begin
                e = q.pop_front();
                if (frame_err !== e.is_err || data_valid !== !e.is_err || data_out !== e.data) begin
                    n_err++;
                    $display("FAIL frame_result: got err=%0b data=%h expected err=%0b data=%h",
                             frame_err, data_out, e.is_err, e.data);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        repeat (3) @(negedge clk);
        chk("reset_data_out", {16'd0, data_out}, 32'h0000);
        chk("reset_valid", {31'd0, data_valid}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(16'hA5C3, 16, 4, 1'b0, 10);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
        chk("data_out_a5c3", {16'd0, data_out}, 32'h0000A5C3);

        send_frame(16'h0000, 16, 2, 1'b0, 1);
        send_frame(16'hFFFF, 16, 2, 1'b0, 1);
        send_frame(16'h8001, 16, 2, 1'b0, 10);

        send_frame(16'h1234, 16, 3, 1'b0, 10);
        send_frame(16'hC3C3, 8, 3, 1'b0, 10);
        chk("held_after_short", {16'd0, data_out}, 32'h00001234);
        send_frame(16'h5555, 17, 3, 1'b0, 10);
        chk("held_after_long", {16'd0, data_out}, 32'h00001234);

        send_frame(16'h0F0F, 16, 3, 1'b1, 10);
        chk("same_cycle_close", {16'd0, data_out}, 32'h00000F0F);

        // Abort 16'hBEEF after 8 bits with a reset; nothing is expected from it.
        @(negedge clk);
        SYNC = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] bw;
            bw = 16'hBEEF;
            DIN = bw[15-i];
            SCLK = 1'b1; repeat (3) @(negedge clk);
            SCLK = 1'b0; repeat (3) @(negedge clk);
        end
        rst_n = 1'b0;
        SYNC = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_good = 16'h0000;
        repeat (6) @(negedge clk);
        chk("abort_data_out", {16'd0, data_out}, 32'h0000);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        send_frame(16'h4321, 16, 3, 1'b0, 10);

`ifdef SERIAL_RX_FRAME_COUNT_EN
        clr_counts = 1'b1; @(negedge clk); clr_counts = 1'b0;
        send_frame(16'h1111, 16, 2, 1'b0, 4);
        send_frame(16'h2222, 5, 2, 1'b0, 4);
        send_frame(16'h3333, 16, 2, 1'b0, 4);
        send_frame(16'h4444, 3, 2, 1'b0, 4);
        send_frame(16'h5555, 16, 2, 1'b0, 10);
        chk("good_count", good_count, 32'd3);
        chk("err_count", err_count, 32'd2);
        clr_counts = 1'b1; @(negedge clk); clr_counts = 1'b0;
        @(negedge clk);
        chk("good_count_clr", good_count, 32'd0);
        chk("err_count_clr", err_count, 32'd0);
`endif

        wait_cycles = 0;
        while (q.size() != 0 && wait_cycles < 100) begin
            @(negedge clk);
            wait_cycles++;
        end
        chk("pending_expected", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
